// File: rtl/fft_scheduler_pkg.sv
// Shared types and constants for the time-multiplexed FFT scheduler.
package fft_sched_pkg;
   localparam int N_REQ      = 4;
   localparam int N_PTS      = 16;
   localparam int W          = 16;
   localparam int N_OUT_BINS = N_PTS / 2;
   localparam int FREQ_W     = 2 * N_OUT_BINS * W;

   typedef logic [W-1:0]          sample_t;
   typedef sample_t [N_PTS-1:0]   frame_t;
   typedef logic [1:0]            slot_t;

   localparam slot_t SLOT_PROC_L = 2'd0;
   localparam slot_t SLOT_PROC_R = 2'd1;
   localparam slot_t SLOT_RAW_L  = 2'd2;
   localparam slot_t SLOT_RAW_R  = 2'd3;
   localparam slot_t SLOT_LAST   = SLOT_RAW_R;

   typedef enum logic [2:0] {IDLE, START, WAIT, STORE, AVG, DONE} state_t;
endpackage

// File: rtl/fft_scheduler_if.sv
// Frame sources, shared FFT engine handshake and spectrum outputs of the scheduler.
interface fft_scheduler_if;
   import fft_sched_pkg::*;

   logic                    i_trigger;
   frame_t [N_REQ-1:0]      i_frame;
   logic                    o_fft_start;
   frame_t                  o_fft_in;
   frame_t                  i_fft_out;
   logic                    i_fft_valid;
   logic [FREQ_W-1:0]       o_freqs;
   logic                    o_done;
   logic                    o_busy;
   logic [N_REQ-1:0]        o_timeout;
   logic                    o_overrun;

   modport master (
      input  i_trigger, i_frame, i_fft_out, i_fft_valid,
      output o_fft_start, o_fft_in, o_freqs, o_done, o_busy, o_timeout, o_overrun
   );

   modport slave (
      output i_trigger, i_frame, i_fft_out, i_fft_valid,
      input  o_fft_start, o_fft_in, o_freqs, o_done, o_busy, o_timeout, o_overrun
   );
endinterface

// File: rtl/fft_byte_avg.sv
// Floor average of two bins, one result per byte lane with no carry between lanes.
module fft_byte_avg
   import fft_sched_pkg::*;
(
   input  sample_t a,
   input  sample_t b,
   output sample_t y
);
   localparam int H = W / 2;

   logic [H:0] sum_hi;
   logic [H:0] sum_lo;

   // Nine-bit lane sums keep the carry inside the lane before halving.
   always_comb begin
      sum_hi = {1'b0, a[W-1:H]} + {1'b0, b[W-1:H]};
      sum_lo = {1'b0, a[H-1:0]} + {1'b0, b[H-1:0]};
      y      = {H'(sum_hi >> 1), H'(sum_lo >> 1)};
   end
endmodule

// File: rtl/fft_scheduler.sv
// Runs four snapshotted frames through one shared FFT engine and publishes
// the lane-averaged L/R spectra as one packed word.
module fft_scheduler
   import fft_sched_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   fft_scheduler_if.master  bus
);
   localparam int CW = $clog2(TIMEOUT + 1);

   state_t                  state;
   state_t                  state_next;
   logic                    trig_prev;
   logic                    trig_edge;
   slot_t                   slot;
   logic [CW-1:0]           wait_cnt;
   logic [CW:0]             wait_nxt;
   logic                    timeout_hit;
   frame_t [N_REQ-1:0]      snapshot;
   frame_t [N_REQ-1:0]      spec_buf;
   sample_t [N_OUT_BINS-1:0] avg01;
   sample_t [N_OUT_BINS-1:0] avg23;
   logic [FREQ_W-1:0]       freqs;
   logic [N_REQ-1:0]        timeout_flags;
   logic                    overrun;

   assign trig_edge   = bus.i_trigger & ~trig_prev;
   assign wait_nxt    = {1'b0, wait_cnt} + 1'b1;
   assign timeout_hit = (wait_nxt == (CW+1)'(TIMEOUT));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (trig_edge) state_next = START;
         START:   state_next = WAIT;
         WAIT:    if (bus.i_fft_valid || timeout_hit) state_next = STORE;
         STORE:   state_next = (slot == SLOT_LAST) ? AVG : START;
         AVG:     state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      bus.o_fft_start = (state == START);
      bus.o_done      = (state == DONE);
      bus.o_busy      = (state != IDLE);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         trig_prev     <= 1'b0;
         overrun       <= 1'b0;
         slot          <= SLOT_PROC_L;
         wait_cnt      <= '0;
         snapshot      <= '0;
         spec_buf      <= '0;
         timeout_flags <= '0;
         freqs         <= '0;
      end else begin
         trig_prev <= bus.i_trigger;
         // A trigger edge outside IDLE is dropped, but reported.
         overrun   <= trig_edge && (state != IDLE);
         case (state)
            IDLE: if (trig_edge) begin
               snapshot      <= bus.i_frame;
               slot          <= SLOT_PROC_L;
               timeout_flags <= '0;
            end
            START: wait_cnt <= '0;
            WAIT: begin
               wait_cnt <= wait_nxt[CW-1:0];
               if (bus.i_fft_valid) begin
                  spec_buf[slot] <= bus.i_fft_out;
               end else if (timeout_hit) begin
                  spec_buf[slot]      <= '0;
                  timeout_flags[slot] <= 1'b1;
               end
            end
            STORE: if (slot != SLOT_LAST) slot <= slot + 1'b1;
            AVG:   freqs <= {avg23, avg01};
            default: ;
         endcase
      end
   end

   // Only bins 0..7 of each averaged pair reach the output word.
   for (genvar k = 0; k < N_OUT_BINS; k++) begin : g_bin
      fft_byte_avg u_avg01 (
         .a (spec_buf[SLOT_PROC_L][k]),
         .b (spec_buf[SLOT_PROC_R][k]),
         .y (avg01[k])
      );
      fft_byte_avg u_avg23 (
         .a (spec_buf[SLOT_RAW_L][k]),
         .b (spec_buf[SLOT_RAW_R][k]),
         .y (avg23[k])
      );
   end

   assign bus.o_fft_in  = snapshot[slot];
   assign bus.o_freqs   = freqs;
   assign bus.o_timeout = timeout_flags;
   assign bus.o_overrun = overrun;
endmodule

// File: tb/tb_fft_scheduler.sv
// Directed bench for fft_scheduler with a latency-3 echo model of the FFT engine.
module tb_fft_scheduler;
   import fft_sched_pkg::*;

   localparam int L    = 3;
   localparam int TMO  = 255;
   localparam int SLOT = L + 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fft_scheduler_if bus ();

   fft_scheduler #(.TIMEOUT(TMO)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus.master)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   int skip_slot  = -1;
   bit stray_on   = 1'b0;
   int sweep_base = 0;

   int     eng_rem   = 0;
   frame_t eng_held;
   int     start_q[$];
   int     done_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Engine model: echoes the frame seen at the start pulse L cycles later.
   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eng_rem         <= 0;
         bus.i_fft_valid <= 1'b0;
         bus.i_fft_out   <= '0;
      end else begin
         bus.i_fft_valid <= 1'b0;
         if (bus.o_fft_start) begin
            eng_rem  <= (start_q.size() - sweep_base == skip_slot) ? 0 : L;
            eng_held <= bus.o_fft_in;
            start_q.push_back(cyc);
            if (stray_on) begin
               bus.i_fft_valid <= 1'b1;
               bus.i_fft_out   <= {N_PTS{16'hBAD0}};
            end
         end else if (eng_rem > 0) begin
            eng_rem <= eng_rem - 1;
            if (eng_rem == 1) begin
               bus.i_fft_valid <= 1'b1;
               bus.i_fft_out   <= eng_held;
            end
         end else if (stray_on && !bus.o_busy) begin
            bus.i_fft_valid <= 1'b1;
            bus.i_fft_out   <= {N_PTS{16'hBAD0}};
         end
      end
   end

   always @(negedge clk) if (bus.o_done) done_q.push_back(cyc);

   typedef struct packed {
      sample_t [3:0] w;
      sample_t       a01;
      sample_t       a23;
   } vec_t;

   vec_t vt[4];

   task automatic chk(input string name, input logic [FREQ_W-1:0] act, input logic [FREQ_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [FREQ_W-1:0] exp_freqs(input sample_t a01, input sample_t a23);
      return {{N_OUT_BINS{a23}}, {N_OUT_BINS{a01}}};
   endfunction

   task automatic set_frames(input sample_t [3:0] w);
      for (int s = 0; s < N_REQ; s++)
         for (int k = 0; k < N_PTS; k++)
            bus.i_frame[s][k] = (k < N_OUT_BINS) ? w[s] : sample_t'(16'hD000 + k * 16 + s);
   endtask

   task automatic to_cycle(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_done(output int t_done);
      t_done = -1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (bus.o_done) begin
            t_done = cyc;
            break;
         end
      end
   endtask

   task automatic launch(input sample_t [3:0] w, input int skip, input bit stray, output int t0);
      set_frames(w);
      skip_slot = skip;
      stray_on  = stray;
      @(posedge clk);
      #1;
      sweep_base    = start_q.size();
      bus.i_trigger = 1'b1;
      t0            = cyc;
      @(posedge clk);
      #1;
      bus.i_trigger = 1'b0;
   endtask

   initial begin
      int t0;
      int td;
      int sb;
      int db;

      vt[0] = '{w: {16'h0000, 16'h0000, 16'h3041, 16'h1020}, a01: 16'h2030, a23: 16'h0000};
      vt[1] = '{w: {16'h0001, 16'h00FF, 16'hFFFF, 16'hFFFF}, a01: 16'hFFFF, a23: 16'h0080};
      vt[2] = '{w: {16'h7FFF, 16'h8001, 16'h0000, 16'h0001}, a01: 16'h0000, a23: 16'h7F80};
      vt[3] = '{w: {16'hEF01, 16'hABCD, 16'h5678, 16'h1234}, a01: 16'h3456, a23: 16'hCD67};

      bus.i_trigger = 1'b0;
      set_frames('0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy",    bus.o_busy,      '0);
      chk("rst_done",    bus.o_done,      '0);
      chk("rst_start",   bus.o_fft_start, '0);
      chk("rst_freqs",   bus.o_freqs,     '0);
      chk("rst_timeout", bus.o_timeout,   '0);
      chk("rst_overrun", bus.o_overrun,   '0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      for (int v = 0; v < 4; v++) begin
         launch(vt[v].w, -1, 1'b0, t0);
         wait_done(td);
         chk($sformatf("v%0d_done_cyc", v), td,          t0 + 4 * SLOT + 2);
         chk($sformatf("v%0d_freqs", v),    bus.o_freqs, exp_freqs(vt[v].a01, vt[v].a23));
         chk($sformatf("v%0d_timeout", v),  bus.o_timeout, '0);
         chk($sformatf("v%0d_starts", v),   start_q.size() - sweep_base, 4);
         for (int i = 0; i < 4; i++)
            chk($sformatf("v%0d_start%0d_cyc", v, i), start_q[sweep_base + i], t0 + 1 + i * SLOT);
         @(negedge clk);
         chk($sformatf("v%0d_busy_after", v), bus.o_busy, '0);
         chk($sformatf("v%0d_freqs_hold", v), bus.o_freqs, exp_freqs(vt[v].a01, vt[v].a23));
      end

      // Slot 2 never answers: it waits out TIMEOUT cycles and contributes zeros.
      launch({16'h0202, 16'h1111, 16'h3041, 16'h1020}, 2, 1'b0, t0);
      wait_done(td);
      chk("tmo_done_cyc", td,            t0 + 3 * SLOT + (TMO + 2) + 2);
      chk("tmo_flags",    bus.o_timeout, 4'b0100);
      chk("tmo_freqs",    bus.o_freqs,   exp_freqs(16'h2030, 16'h0101));

      // Second edge mid-sweep is dropped and reported one cycle later.
      launch(vt[0].w, -1, 1'b0, t0);
      db = done_q.size();
      to_cycle(t0 + 5);
      bus.i_trigger = 1'b1;
      set_frames(vt[1].w);
      @(negedge clk);
      chk("ovr_pre",  bus.o_overrun, '0);
      to_cycle(t0 + 6);
      @(negedge clk);
      chk("ovr_pulse", bus.o_overrun, 1'b1);
      chk("ovr_tmo_cleared", bus.o_timeout, '0);
      to_cycle(t0 + 7);
      bus.i_trigger = 1'b0;
      @(negedge clk);
      chk("ovr_post", bus.o_overrun, '0);
      to_cycle(t0 + 40);
      chk("ovr_done_count", done_q.size() - db, 1);
      chk("ovr_freqs",      bus.o_freqs, exp_freqs(vt[0].a01, vt[0].a23));

      // Reset in the middle of a sweep.
      launch(vt[2].w, -1, 1'b0, t0);
      to_cycle(t0 + 12);
      rst_n = 1'b0;
      sb = start_q.size();
      db = done_q.size();
      @(negedge clk);
      chk("mrst_busy",  bus.o_busy,      '0);
      chk("mrst_freqs", bus.o_freqs,     '0);
      chk("mrst_start", bus.o_fft_start, '0);
      chk("mrst_fftin", bus.o_fft_in,    '0);
      to_cycle(t0 + 14);
      rst_n = 1'b1;
      to_cycle(t0 + 50);
      chk("mrst_no_start", start_q.size() - sb, 0);
      chk("mrst_no_done",  done_q.size() - db,  0);
      launch(vt[2].w, -1, 1'b0, t0);
      wait_done(td);
      chk("mrst_rerun_done", td,          t0 + 4 * SLOT + 2);
      chk("mrst_rerun_freqs", bus.o_freqs, exp_freqs(vt[2].a01, vt[2].a23));

      // Stray valid in IDLE and START must not disturb the results.
      launch(vt[3].w, -1, 1'b1, t0);
      wait_done(td);
      stray_on = 1'b0;
      chk("stray_done",  td,            t0 + 4 * SLOT + 2);
      chk("stray_freqs", bus.o_freqs,   exp_freqs(vt[3].a01, vt[3].a23));
      chk("stray_tmo",   bus.o_timeout, '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=expired required=finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/fft_scheduler.md
# fft_scheduler

Time-multiplexes one shared 16-point FFT engine across four audio frame sources: processed L/R after gate/pan, and raw L/R from the ADC. This replaces four parallel FFT instances. On a trigger edge it snapshots all four frames, runs them through the engine in fixed order, and averages the L/R spectra per byte lane. It then publishes a packed 256-bit spectrum word with a done pulse. It sits between the audio front end and the spectrum display path, on the system clock domain.

## Interface
- N_REQ, 4, number of frame sources (fixed order 0..3)
- N_PTS, 16, samples per frame / bins per FFT
- W, 16, sample and bin width
- TIMEOUT, 255, max WAIT cycles before a slot is abandoned
- i_clk  in  1  system clock, all logic rising-edge
- i_rst_n  in  1  asynchronous active-low reset
- i_trigger  in  1  sweep request; a sweep starts on the rising edge only
- i_frame  in  [N_REQ][N_PTS] x W  source frames; 0=proc L, 1=proc R, 2=raw L, 3=raw R
- o_fft_start  out  1  one-cycle start pulse to the engine
- o_fft_in  out  [N_PTS] x W  engine input, held stable from START through WAIT
- i_fft_out  in  [N_PTS] x W  engine result
- i_fft_valid  in  1  engine result valid; sampled only in WAIT
- o_freqs  out  256  packed spectrum, registered
- o_done  out  1  one-cycle pulse when o_freqs updates
- o_busy  out  1  high in every state except IDLE
- o_timeout  out  4  per-slot sticky timeout flags, cleared at sweep start
- o_overrun  out  1  one-cycle pulse when a trigger edge is dropped while busy

## Operation
- Edge detect: register i_trigger; edge = i_trigger & ~prev. prev resets to 0.
- States:
  - IDLE: on edge, snapshot all four i_frame entries, set slot=0, clear o_timeout, go to START.
  - START: assert o_fft_start; drive o_fft_in = snapshot[slot]; clear wait counter; go to WAIT.
  - WAIT: increment counter each cycle. If i_fft_valid, latch i_fft_out into buf[slot] and go to STORE. Otherwise, if counter == TIMEOUT, write zeros to buf[slot], set o_timeout[slot], and go to STORE.
  - STORE: if slot==3 go to AVG; else slot++ and go to START.
  - AVG: register o_freqs and go to DONE.
  - DONE: o_done=1 for this cycle; go to IDLE.
- Valid and timeout in the same cycle: valid wins, no flag.
- i_fft_valid outside WAIT is ignored.
- An edge in any state other than IDLE is dropped and pulses o_overrun the next cycle. The snapshot is untouched.
- Averaging, per bin k, per byte lane h∈{[15:8],[7:0]}: avg = (a.h + b.h) >> 1, using a 9-bit unsigned sum, floor, lanes independent (no carry between lanes).
  - A01[k] = avg(buf0[k], buf1[k])
  - A23[k] = avg(buf2[k], buf3[k])
- Packing: o_freqs[16k+15:16k] = A01[k] for k=0..7; o_freqs[128+16k+15:128+16k] = A23[k]. Bins 8..15 are discarded.
- o_freqs holds its value between sweeps.

## Timing
- Reset values: all outputs 0, state IDLE, slot 0, snapshot/buf 0, o_freqs 0.
- Engine latency L (valid L cycles after the start pulse, L≥1); edge seen in IDLE at cycle 0.
  - Slot i START at cycle 1+i(L+2).
  - AVG at cycle 4(L+2)+1.
  - o_done high and new o_freqs visible at cycle 4(L+2)+2.
  - o_busy drops at 4(L+2)+3.
- Worst case with all slots timing out: o_done at 4(TIMEOUT+2)+2.
- Reset mid-sweep: immediate return to reset values. No o_done. The engine sees no further start pulse.
- A new edge is accepted earliest in the cycle after DONE (IDLE).

## Structure
- fft_sched_pkg:
  - state enum {IDLE, START, WAIT, STORE, AVG, DONE}
  - N_REQ, N_PTS, W
  - typedefs sample_t (logic [W-1:0]) and frame_t (sample_t [N_PTS])
  - slot index constants
- Sub-module fft_byte_avg: combinational per-lane average of two W-bit bins, instantiated 16 times (8 bins × 2 pairs).

## Test plan
- Engine model L=3; frames set so buf0[k]=16'h1020, buf1[k]=16'h3041, buf2=buf3=16'h0000; edge at cycle 0 -> o_fft_start at cycles 1, 6, 11, 16; o_done at cycle 22; A01 lanes = 16'h2030, upper 128 bits = 0.
- Lane overflow: buf0=16'hFFFF, buf1=16'hFFFF -> A01=16'hFFFF; buf0=16'h00FF, buf1=16'h0001 -> 16'h0080, no carry into the high lane.
- Engine never asserts valid for slot 2, TIMEOUT=255 -> slot 2 waits 255 cycles; o_timeout=4'b0100; A23 = avg(0, buf3); o_done still pulses.
- Second trigger edge at cycle 5 during a sweep -> o_overrun pulse at cycle 6; snapshot unchanged; exactly one o_done.
- Deassert i_rst_n at cycle 12 -> all outputs 0 next edge, o_freqs 0, no o_done; a new edge after release runs a full sweep.
- Stray i_fft_valid in IDLE and START -> ignored; results match the golden model.
